pdu_dma_fetcher: RTL and testbench

Consumer end of the PDU ring buffer's DMA request interface. The block accepts one `dma_start` request at a time (base address, flit count, queue id), streams the requested flits out of the ring buffer's read port, and presents them as a back-pressured flit stream with sop/eop/queue tags toward the PCIe write path. It pulses `dma_done` once the last flit has been accepted downstream, which frees the ring buffer to issue its next request.

---
 rtl/pdu_dma_fetcher.sv | 166 ++++++++++++++++
 tb/tb_pdu_dma_fetcher.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdu_dma_fetcher.sv
// rtl/pdu_dma_fetcher.sv - ring buffer DMA request consumer streaming flits to the PCIe write path
module pdu_dma_fetcher #(
  parameter int PDU_DEPTH     = 512,
  parameter int PDU_AWIDTH    = $clog2(PDU_DEPTH),
  parameter int THRESHOLD     = 64,
  parameter int APP_IDX_WIDTH = 12,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dma_start,
  input  logic [PDU_AWIDTH-1:0]    dma_size,
  input  logic [PDU_AWIDTH-1:0]    dma_base_addr,
  input  logic [APP_IDX_WIDTH-1:0] dma_queue,
  output logic                     dma_done,
  output logic [PDU_AWIDTH-1:0]    rd_addr,
  output logic                     rd_en,
  input  logic                     rd_valid,
  input  logic [511:0]             rd_data,
  output logic [511:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [APP_IDX_WIDTH-1:0] out_queue,
  output logic                     busy
);
  localparam int MAX_SLOT = PDU_DEPTH - THRESHOLD;
  localparam int FPW      = $clog2(FIFO_DEPTH);
  localparam int FCW      = FPW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [PDU_AWIDTH-1:0]    ptr_q, ptr_d, rem_q, rem_d, size_q, size_d;
  logic [PDU_AWIDTH-1:0]    push_cnt_q, push_cnt_d, ptr_inc;
  logic [APP_IDX_WIDTH-1:0] queue_q, queue_d;
  logic                     sop_pend_q, sop_pend_d;
  logic [1:0]               dly_q, dly_d;
  logic [1:0]               inflight_q, inflight_d;
  logic [FCW-1:0]           cnt_q, cnt_d;
  logic [FCW:0]             occupancy;
  logic [FPW-1:0]           wp_q, rp_q;
  logic [511:0]             mem_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    mem_sop_q, mem_eop_q;
  logic                     push, pop, credit_ok, eop_flag;

  // Returns with no read outstanding are leftovers from before a reset.
  assign push      = rd_valid && (inflight_q != 2'd0);
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_data_q[rp_q];
  assign out_sop   = out_valid && mem_sop_q[rp_q];
  assign out_eop   = out_valid && mem_eop_q[rp_q];
  assign out_queue = queue_q;
  assign rd_addr   = ptr_q;
  assign busy      = (state_q != IDLE);
  assign eop_flag  = ((push_cnt_q + PDU_AWIDTH'(1)) == size_q);
  assign ptr_inc   = ptr_q + PDU_AWIDTH'(1);

  // Same-cycle pops are not credited, so the skid FIFO can never overflow.
  assign occupancy = (FCW+1)'(cnt_q) + (FCW+1)'(inflight_q);
  assign credit_ok = (occupancy < (FCW+1)'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    size_d     = size_q;
    queue_d    = queue_q;
    sop_pend_d = sop_pend_q;
    push_cnt_d = push_cnt_q;
    dly_d      = dly_q;
    rd_en      = 1'b0;
    dma_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dma_start) begin
          ptr_d      = dma_base_addr;
          rem_d      = dma_size;
          size_d     = dma_size;
          queue_d    = dma_queue;
          sop_pend_d = 1'b1;
          push_cnt_d = '0;
          if (dma_size != '0) begin
            state_d = FETCH;
          end else begin
            state_d = DONE;
            dly_d   = 2'd2;
          end
        end
      end
      FETCH: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          ptr_d = (ptr_inc >= PDU_AWIDTH'(MAX_SLOT)) ? '0 : ptr_inc;
          rem_d = rem_q - PDU_AWIDTH'(1);
          if (rem_q == PDU_AWIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_eop) state_d = DONE;
      end
      DONE: begin
        if (dly_q != 2'd0) begin
          dly_d = dly_q - 2'd1;
        end else begin
          dma_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (push) begin
      sop_pend_d = 1'b0;
      push_cnt_d = push_cnt_q + PDU_AWIDTH'(1);
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (rd_en && !push)      inflight_d = inflight_q + 2'd1;
    else if (!rd_en && push) inflight_d = inflight_q - 2'd1;
    cnt_d = cnt_q;
    if (push && !pop)        cnt_d = cnt_q + FCW'(1);
    else if (!push && pop)   cnt_d = cnt_q - FCW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      size_q     <= '0;
      queue_q    <= '0;
      sop_pend_q <= 1'b0;
      push_cnt_q <= '0;
      dly_q      <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      mem_sop_q  <= '0;
      mem_eop_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_data_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      size_q     <= size_d;
      queue_q    <= queue_d;
      sop_pend_q <= sop_pend_d;
      push_cnt_q <= push_cnt_d;
      dly_q      <= dly_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      if (push) begin
        mem_data_q[wp_q] <= rd_data;
        mem_sop_q[wp_q]  <= sop_pend_q;
        mem_eop_q[wp_q]  <= eop_flag;
        wp_q             <= wp_q + FPW'(1);
      end
      if (pop) rp_q <= rp_q + FPW'(1);
    end
  end
endmodule

// File: tb/tb_pdu_dma_fetcher.sv
// tb/tb_pdu_dma_fetcher.sv - scoreboard bench for pdu_dma_fetcher
module tb_pdu_dma_fetcher;
  typedef logic [525:0] flit_t;
  typedef struct {int cyc; flit_t f;} obs_t;
  typedef struct {int cyc; logic [8:0] a;} rd_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         dma_start = 1'b0;
  logic [8:0]   dma_size = '0, dma_base_addr = '0;
  logic [11:0]  dma_queue = '0;
  logic         dma_done, rd_en, rd_valid, out_valid, out_sop, out_eop, busy;
  logic         out_ready = 1'b1;
  logic [8:0]   rd_addr;
  logic [511:0] rd_data, out_data;
  logic [11:0]  out_queue;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_viol = 0;
  int occ_viol = 0;
  int occ = 0;
  logic  prev_stall = 1'b0;
  flit_t prev_f = '0;

  flit_t exp_q[$];
  obs_t  obs_q[$];
  rd_t   rd_q[$];
  int    done_q[$];

  logic       p1_v = 1'b0, p2_v = 1'b0;
  logic [8:0] p1_a = '0, p2_a = '0;

  pdu_dma_fetcher dut (
    .clk(clk), .rst(rst), .dma_start(dma_start), .dma_size(dma_size),
    .dma_base_addr(dma_base_addr), .dma_queue(dma_queue), .dma_done(dma_done),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_queue(out_queue), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input logic [8:0] a);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = {7'h0, a, 16'(i * 4099) ^ 16'h5A3C};
    return r;
  endfunction

  // Ring buffer read port: two-cycle latency, not reset so stale returns survive rst.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    p1_v <= rd_en;
    p1_a <= rd_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign rd_valid = p2_v;
  assign rd_data  = pat(p2_a);

  always @(negedge clk) begin
    flit_t cur;
    cur = {out_sop, out_eop, out_queue, out_data};
    if (prev_stall && (!out_valid || cur !== prev_f)) stall_viol++;
    prev_stall = out_valid && !out_ready;
    prev_f = cur;
    if (out_valid && out_ready) obs_q.push_back('{cyc, cur});
    if (dma_done) done_q.push_back(cyc);
    if (rd_en) rd_q.push_back('{cyc, rd_addr});
    if (rst) occ = 0;
    else occ = occ + int'(rd_en) - int'(out_valid && out_ready);
    if (occ > 4) occ_viol++;
  end

  task automatic clear_obs();
    obs_q.delete(); rd_q.delete(); done_q.delete(); exp_q.delete();
  endtask

  task automatic start_req(input int base, input int size, input int q, output int t);
    int a;
    @(posedge clk); #1;
    dma_start = 1'b1; dma_base_addr = 9'(base); dma_size = 9'(size); dma_queue = 12'(q);
    t = cyc;
    a = base;
    for (int i = 0; i < size; i++) begin
      exp_q.push_back({1'(i == 0), 1'(i == size - 1), 12'(q), pat(9'(a))});
      a = (a + 1 >= 448) ? 0 : a + 1;
    end
    @(posedge clk); #1;
    dma_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int mode, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (mode == 1) out_ready = (k % 4 == 0) || (k % 4 == 3);
      if (done_q.size() > 0) begin ok = 1'b1; break; end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++;
    if ({dma_done, rd_en, out_valid, out_sop, out_eop, busy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 000000", {dma_done, rd_en, out_valid, out_sop, out_eop, busy});
    end
    n_assert++;
    if (rd_addr !== 9'd0 || out_queue !== 12'd0 || out_data !== 512'd0) begin
      n_fail++; $display("FAIL reset_data rd_addr=%0d out_queue=%0d want 0", rd_addr, out_queue);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int t; bit ok; obs_t o; flit_t e;
    clear_obs();
    start_req(10, 3, 5, t);
    wait_done(40, 0, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout got no dma_done want one"); end
    n_assert++;
    if (rd_q.size() != 3) begin n_fail++; $display("FAIL basic_rd_count got %0d want 3", rd_q.size()); end
    for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
      n_assert++;
      if (rd_q[i].a !== 9'(10 + i) || rd_q[i].cyc != t + 1 + i) begin
        n_fail++; $display("FAIL basic_rd%0d got addr %0d cyc %0d want addr %0d cyc %0d", i, rd_q[i].a, rd_q[i].cyc, 10 + i, t + 1 + i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_assert++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL basic_flit%0d got none want flit", i); continue; end
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.f !== e || o.cyc != t + 4 + i) begin
        n_fail++; $display("FAIL basic_flit%0d got %h @%0d want %h @%0d", i, o.f[525:500], o.cyc, e[525:500], t + 4 + i);
      end
    end
    n_assert++;
    if (done_q.size() != 1 || done_q[0] != t + 7) begin
      n_fail++; $display("FAIL basic_done got %0d pulses first @%0d want 1 @%0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t + 7);
    end
  endtask

  task automatic test_wrap();
    int t; bit ok; obs_t o; flit_t e;
    int want_a[3] = '{446, 447, 0};
    clear_obs();
    start_req(446, 3, 7, t);
    wait_done(40, 0, ok);
    repeat (4) @(posedge clk);
    n_assert++;
    if (rd_q.size() != 3) begin n_fail++; $display("FAIL wrap_rd_count got %0d want 3", rd_q.size()); end
    for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
      n_assert++;
      if (rd_q[i].a !== 9'(want_a[i])) begin n_fail++; $display("FAIL wrap_rd%0d got %0d want %0d", i, rd_q[i].a, want_a[i]); end
    end
    n_assert++;
    if (obs_q.size() != 3) begin n_fail++; $display("FAIL wrap_flit_count got %0d want 3", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_assert++;
      if (o.f !== e) begin n_fail++; $display("FAIL wrap_flit got %h want %h", o.f[525:500], e[525:500]); end
    end
    n_assert++;
    if (!ok || done_q.size() != 1) begin n_fail++; $display("FAIL wrap_done got %0d pulses want 1", done_q.size()); end
  endtask

  task automatic test_backpressure();
    int t; bit ok; obs_t o; flit_t e; int sv0, ov0;
    clear_obs();
    sv0 = stall_viol; ov0 = occ_viol;
    start_req(100, 8, 12'hABC, t);
    wait_done(200, 1, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout got no dma_done want one"); end
    n_assert++;
    if (obs_q.size() != 8) begin n_fail++; $display("FAIL bp_flit_count got %0d want 8", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_assert++;
      if (o.f !== e) begin n_fail++; $display("FAIL bp_flit got %h want %h", o.f[525:500], e[525:500]); end
    end
    n_assert++;
    if (stall_viol != sv0) begin n_fail++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_viol - sv0); end
    n_assert++;
    if (occ_viol != ov0) begin n_fail++; $display("FAIL bp_occupancy got %0d overflows want 0", occ_viol - ov0); end
    n_assert++;
    if (done_q.size() != 1) begin n_fail++; $display("FAIL bp_done got %0d pulses want 1", done_q.size()); end
  endtask

  task automatic test_small_sizes();
    int t; bit ok; obs_t o; flit_t e;
    clear_obs();
    start_req(30, 1, 1, t);
    wait_done(40, 0, ok);
    n_assert++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL size1_count got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_assert++;
      if (o.f !== e || o.f[525:524] !== 2'b11) begin n_fail++; $display("FAIL size1_flit got %h want %h", o.f[525:500], e[525:500]); end
      n_assert++;
      if (done_q.size() != 1 || done_q[0] != o.cyc + 1) begin
        n_fail++; $display("FAIL size1_done got %0d pulses first @%0d want 1 @%0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, o.cyc + 1);
      end
    end
    repeat (2) @(posedge clk);
    clear_obs();
    start_req(20, 0, 3, t);
    wait_done(40, 0, ok);
    n_assert++;
    if (!ok || done_q[0] != t + 3) begin
      n_fail++; $display("FAIL size0_done got @%0d want @%0d", ok ? done_q[0] : -1, t + 3);
    end
    n_assert++;
    if (rd_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL size0_idle got %0d reads %0d flits want 0 0", rd_q.size(), obs_q.size());
    end
  endtask

  task automatic test_ignore_start();
    int t; bit ok; obs_t o; flit_t e;
    clear_obs();
    start_req(50, 4, 9, t);
    @(posedge clk); #1;
    dma_start = 1'b1; dma_base_addr = 9'd200; dma_size = 9'd2; dma_queue = 12'd1;
    @(posedge clk); #1;
    dma_start = 1'b0;
    wait_done(40, 0, ok);
    repeat (10) @(posedge clk);
    n_assert++;
    if (!ok || done_q.size() != 1) begin n_fail++; $display("FAIL ignore_done got %0d pulses want 1", done_q.size()); end
    n_assert++;
    if (rd_q.size() != 4) begin n_fail++; $display("FAIL ignore_rd_count got %0d want 4", rd_q.size()); end
    for (int i = 0; i < rd_q.size(); i++) begin
      n_assert++;
      if (rd_q[i].a !== 9'(50 + i)) begin n_fail++; $display("FAIL ignore_rd%0d got %0d want %0d", i, rd_q[i].a, 50 + i); end
    end
    n_assert++;
    if (obs_q.size() != 4) begin n_fail++; $display("FAIL ignore_flit_count got %0d want 4", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_assert++;
      if (o.f !== e) begin n_fail++; $display("FAIL ignore_flit got %h want %h", o.f[525:500], e[525:500]); end
    end
  endtask

  task automatic test_reset_mid();
    int t; bit ok; obs_t o; flit_t e;
    clear_obs();
    start_req(300, 6, 2, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({busy, rd_en, out_valid, out_sop, out_eop, dma_done} !== 6'b0 || rd_addr !== 9'd0 || out_queue !== 12'd0) begin
      n_fail++; $display("FAIL rstmid_outputs got ctrl %b addr %0d queue %0d want 0", {busy, rd_en, out_valid, out_sop, out_eop, dma_done}, rd_addr, out_queue);
    end
    repeat (8) @(posedge clk);
    n_assert++;
    if (obs_q.size() != 0 || done_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_quiet got %0d flits %0d done want 0 0", obs_q.size(), done_q.size());
    end
    clear_obs();
    start_req(5, 2, 4, t);
    wait_done(40, 0, ok);
    n_assert++;
    if (!ok || obs_q.size() != 2) begin n_fail++; $display("FAIL rstmid_after got %0d flits want 2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_assert++;
      if (o.f !== e) begin n_fail++; $display("FAIL rstmid_flit got %h want %h", o.f[525:500], e[525:500]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_small_sizes();
    test_ignore_start();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
